// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the fetch/LSU memory-port arbiter.
// Owner and state encodings are referenced by the arbiter top and its winner-select helper.
package mem_arb_pkg;

  typedef enum logic {FETCH = 1'b0, DATA = 1'b1} owner_t;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int WADDR_W  = 30;
  localparam int LAT_W    = 3;
  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select between fetch and data requests.
// Data wins unless fetch has already waited through MAX_STREAK data grants.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic                i_valid,
  input  logic                d_valid,
  input  logic [STREAK_W-1:0] streak,
  output logic                pick_fetch,
  output logic                pick_data
);

  // priority decode with starvation override for fetch
  always_comb begin
    pick_fetch = 1'b0;
    pick_data  = 1'b0;
    if (i_valid && d_valid && (streak == STREAK_W'(MAX_STREAK))) begin
      pick_fetch = 1'b1;
    end else if (d_valid) begin
      pick_data = 1'b1;
    end else if (i_valid) begin
      pick_fetch = 1'b1;
    end else begin
      pick_fetch = 1'b0;
      pick_data  = 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the load/store unit.
// One access in flight; its response returns MEM_LAT cycles after the grant.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_valid,
  input  logic [31:0]        i_addr,
  output logic               i_ready,
  input  logic               i_flush,
  output logic               i_rvalid,
  output logic [31:0]        i_rdata,
  input  logic               d_valid,
  input  logic               d_we,
  input  logic [31:0]        d_addr,
  input  logic [31:0]        d_wdata,
  output logic               d_ready,
  output logic               d_rvalid,
  output logic [31:0]        d_rdata,
  output logic               m_en,
  output logic               m_we,
  output logic [WADDR_W-1:0] m_addr,
  output logic [31:0]        m_wdata,
  input  logic [31:0]        m_rdata
);

  state_t              state_r;
  owner_t              owner_r;
  logic                was_write_r;
  logic [LAT_W-1:0]    lat_cnt_r;
  logic [STREAK_W-1:0] streak_r;
  logic                drop_r;

  logic can_accept_s, pick_fetch_s, pick_data_s;
  logic grant_i_s, grant_d_s, accept_s, resp_s;
  logic unused_s;

  assign unused_s = ^{i_addr[1:0], d_addr[1:0]};

  mem_arb_pick #(.MAX_STREAK(MAX_STREAK)) u_pick (
    .i_valid    (i_valid),
    .d_valid    (d_valid),
    .streak     (streak_r),
    .pick_fetch (pick_fetch_s),
    .pick_data  (pick_data_s)
  );

  // the response cycle doubles as an accept slot so back-to-back accesses keep the port busy
  assign can_accept_s = (state_r == IDLE) || (lat_cnt_r == LAT_W'(1));
  assign grant_d_s    = rstn & can_accept_s & pick_data_s;
  assign grant_i_s    = rstn & can_accept_s & pick_fetch_s;
  assign accept_s     = grant_d_s | grant_i_s;
  assign resp_s       = rstn & (state_r == BUSY) & (lat_cnt_r == LAT_W'(1));

  // transaction tracking and fetch-starvation streak
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= IDLE;
      owner_r     <= FETCH;
      was_write_r <= 1'b0;
      lat_cnt_r   <= LAT_W'(0);
      streak_r    <= STREAK_W'(0);
      drop_r      <= 1'b0;
    end else begin
      if (accept_s) begin
        state_r     <= BUSY;
        owner_r     <= grant_d_s ? DATA : FETCH;
        was_write_r <= grant_d_s & d_we;
        lat_cnt_r   <= LAT_W'(MEM_LAT);
        drop_r      <= 1'b0;
      end else if (state_r == BUSY) begin
        if (lat_cnt_r == LAT_W'(1)) begin
          state_r   <= IDLE;
          lat_cnt_r <= LAT_W'(0);
          drop_r    <= 1'b0;
        end else begin
          lat_cnt_r <= lat_cnt_r - LAT_W'(1);
          drop_r    <= drop_r | (i_flush & (owner_r == FETCH));
        end
      end

      if (grant_d_s) begin
        if (!i_valid) streak_r <= STREAK_W'(0);
        else if (streak_r != STREAK_W'(MAX_STREAK)) streak_r <= streak_r + STREAK_W'(1);
      end else if (grant_i_s) begin
        streak_r <= STREAK_W'(0);
      end
    end
  end

  // handshake, memory drive and response steering
  always_comb begin
    i_ready  = grant_i_s;
    d_ready  = grant_d_s;
    m_en     = accept_s;
    m_we     = grant_d_s & d_we;
    m_addr   = {WADDR_W{1'b0}};
    m_wdata  = 32'd0;
    i_rvalid = 1'b0;
    i_rdata  = 32'd0;
    d_rvalid = 1'b0;
    d_rdata  = 32'd0;
    if (grant_d_s) begin
      m_addr  = d_addr[31:2];
      m_wdata = d_wdata;
    end else if (grant_i_s) begin
      m_addr  = i_addr[31:2];
    end else begin
      m_addr  = {WADDR_W{1'b0}};
    end
    if (resp_s && (owner_r == FETCH)) begin
      i_rvalid = ~drop_r & ~i_flush;
      i_rdata  = i_rvalid ? m_rdata : 32'd0;
    end else if (resp_s && (owner_r == DATA)) begin
      d_rvalid = 1'b1;
      d_rdata  = was_write_r ? 32'd0 : m_rdata;
    end else begin
      i_rvalid = 1'b0;
      d_rvalid = 1'b0;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the core's single memory port between instruction fetch and the load/store unit. Accepts one request per grant with a valid/ready handshake, drives the memory, and returns read data to the winning requester after a fixed memory latency. Data accesses have priority; a streak counter guarantees fetch progress. The arbiter sits between the fetch/LSU stages and the unified BRAM.

## Interface
- MEM_LAT, 1: memory read latency in cycles (1..4); data valid MEM_LAT cycles after m_en
- MAX_STREAK, 4: consecutive data grants allowed while fetch waits (1..15)
- clk  in  1  clock
- rstn  in  1  synchronous, active-low reset
- i_valid  in  1  fetch request
- i_addr  in  32  fetch byte address (bits [1:0] ignored)
- i_ready  out  1  fetch request accepted this cycle
- i_flush  in  1  discard any outstanding fetch response
- i_rvalid  out  1  fetch data valid (one-cycle pulse)
- i_rdata  out  32  fetch data
- d_valid  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address (bits [1:0] ignored)
- d_wdata  in  32  write data
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  read data / write ack (one-cycle pulse)
- d_rdata  out  32  read data (0 on write ack)
- m_en  out  1  memory enable
- m_we  out  1  memory write enable
- m_addr  out  30  word address = addr[31:2]
- m_wdata  out  32  memory write data
- m_rdata  in  32  memory read data

## Operation
- States: IDLE, BUSY. Registers: state, owner (FETCH/DATA), was_write, lat_cnt, streak, drop.
- can_accept = IDLE, or BUSY with lat_cnt == 1 (response cycle).
- Winner when can_accept: if both valid and streak == MAX_STREAK, fetch; else data if d_valid; else fetch if i_valid; else none.
- Accept: winner's ready = 1 (combinational); m_en = 1, m_we = d_we & (owner==DATA), m_addr/m_wdata from winner; next state BUSY, lat_cnt <= MEM_LAT, owner/was_write latched, drop <= 0.
- Loser's ready = 0; requester must hold valid and payload until ready.
- BUSY: lat_cnt decrements each cycle. At lat_cnt == 1, pulse owner's rvalid with rdata = m_rdata (d_rdata = 0 if was_write). If no new accept, go IDLE.
- Streak: data grant while i_valid high -> streak+1; data grant with i_valid low -> 0; fetch grant -> 0. Saturates at MAX_STREAK.
- Flush: i_flush while owner==FETCH in BUSY sets drop; i_flush in the response cycle also suppresses. Dropped response: i_rvalid = 0. Flush never affects data transactions or a fetch accepted in the same cycle.
- When not pulsing, rvalid = 0 and rdata = 0. m_en = 0 when no accept; m_addr/m_wdata/m_we = 0.

## Timing
- Reset: state IDLE, streak 0, lat_cnt 0, drop 0; all outputs 0 (ready combinational, reflecting valid in IDLE).
- Accept at cycle t -> rvalid at t+MEM_LAT. Next accept possible at t+MEM_LAT; throughput one access per MEM_LAT cycles (every cycle for MEM_LAT=1).
- Simultaneous response and new accept: response goes to the old owner; the new request drives memory the same cycle.
- Reset mid-transaction: outstanding response discarded, no rvalid after rstn rises.
- Write ack timed as read (t+MEM_LAT); memory write occurs at t.

## Structure
- mem_arb_pkg: owner_t enum (FETCH, DATA), state_t enum (IDLE, BUSY), word-address width constant 30.
- Sub-module mem_arb_pick: combinational winner select from i_valid, d_valid, streak, MAX_STREAK.

## Test plan
- MEM_LAT=1, fetch only, i_addr 0x0,0x4,0x8 back-to-back -> i_ready each cycle, m_addr 0,1,2, i_rvalid one cycle later each, data matches memory.
- Both valid same cycle, d_we=0 d_addr 0x100 -> d_ready=1, i_ready=0; d_rvalid at t+1 with mem[0x40]; fetch accepted at t+1.
- MEM_LAT=1, MAX_STREAK=4, d_valid and i_valid held high -> 4 data grants, then 1 fetch grant, pattern repeats.
- MEM_LAT=3, d_we=1 d_addr 0x20 d_wdata 0xDEADBEEF -> m_we=1 m_addr 8 at t; d_rvalid at t+3 with d_rdata 0; readback returns 0xDEADBEEF.
- MEM_LAT=2, fetch accepted at t, i_flush at t+1 -> no i_rvalid at t+2; fetch accepted at t+2 returns data at t+4.
- rstn low at t+1 after accept with MEM_LAT=3 -> no rvalid at t+3; all outputs 0 during reset; clean accept after release.
